// File: rtl/ab_gates_pkg.sv
// ab_gates_pkg: shared operation encoding and default width for the ab_gates unit
package ab_gates_pkg;
  localparam int WIDTH_DEFAULT = 64;
  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_ZERO = 2'd3
  } op_e;
endpackage

// File: rtl/ab_gates_bit.sv
// ab_gates_bit: one combinational result bit built from gate primitives and a 4:1 mux
module mux_4to1 (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       y
);
  assign y = d[sel];
endmodule

module ab_gates_bit
  import ab_gates_pkg::*;
(
  input  logic a,
  input  logic b,
  input  op_e  ctrl,
  output logic out
);
  logic and_y, or_y, xor_y;
  and g_and (and_y, a, b);
  or  g_or  (or_y,  a, b);
  xor g_xor (xor_y, a, b);
  // Mux input order mirrors the op_e encoding; the last leg is tied low.
  mux_4to1 u_mux (
    .d  ({1'b0, xor_y, or_y, and_y}),
    .sel(ctrl),
    .y  (out)
  );
endmodule

// File: rtl/ab_gates_unit.sv
// ab_gates_unit: registered bitwise AND/OR/XOR/zero unit with one-cycle latency
module ab_gates_unit
  import ab_gates_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       ctrl,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             zero
);
  logic [WIDTH-1:0] result;
  op_e              op;
  assign op = op_e'(ctrl);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ab_gates_bit u_bit (
      .a   (a[i]),
      .b   (b[i]),
      .ctrl(op),
      .out (result[i])
    );
  end
  // Capture only on in_valid so idle-cycle inputs never reach the outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out       <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out  <= result;
        zero <= ~|result;
      end
    end
  end
endmodule

// File: tb/tb_ab_gates_unit.sv
// tb_ab_gates_unit: directed vectors plus a per-cycle behavioural model check
module tb_ab_gates_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] a, b;
  logic [1:0]  ctrl;
  logic        in_valid;
  logic [63:0] out;
  logic        out_valid, zero;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] m_out;
  logic        m_zero, m_valid;
  bit          m_ok = 1'b0;

  ab_gates_unit #(.WIDTH(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .ctrl     (ctrl),
    .in_valid (in_valid),
    .out      (out),
    .out_valid(out_valid),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] op_model(input logic [1:0] c, input logic [63:0] x, input logic [63:0] y);
    case (c)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: what the outputs must be after each rising edge.
  always @(posedge clk) begin
    if (!reset) begin
      m_out   = 64'd0;
      m_zero  = 1'b1;
      m_valid = 1'b0;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        m_out  = op_model(ctrl, a, b);
        m_zero = (m_out == 64'd0);
      end
    end
    m_ok = 1'b1;
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_out", out, m_out);
      chk("model_zero", {63'd0, zero}, {63'd0, m_zero});
      chk("model_valid", {63'd0, out_valid}, {63'd0, m_valid});
    end
  end

  task automatic apply(input logic r, input logic v, input logic [1:0] c, input logic [63:0] aa, input logic [63:0] bb);
    @(negedge clk);
    reset = r; in_valid = v; ctrl = c; a = aa; b = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string name, input logic [63:0] eo, input logic ez, input logic ev);
    chk({name, "_out"}, out, eo);
    chk({name, "_zero"}, {63'd0, zero}, {63'd0, ez});
    chk({name, "_valid"}, {63'd0, out_valid}, {63'd0, ev});
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b1; ctrl = 2'd1; a = '1; b = '1;
    @(posedge clk); #1;
    expect3("reset1", 64'd0, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 2'd1, '1, '1);
    expect3("reset2", 64'd0, 1'b1, 1'b0);

    apply(1'b1, 1'b1, 2'd0, 64'h3, 64'h5);
    expect3("tt_and", 64'h1, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 2'd1, 64'h3, 64'h5);
    expect3("tt_or", 64'h7, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 2'd2, 64'h3, 64'h5);
    expect3("tt_xor", 64'h6, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 2'd3, 64'h3, 64'h5);
    expect3("tt_zero", 64'h0, 1'b1, 1'b1);
    apply(1'b1, 1'b1, 2'd3, '1, '1);
    expect3("zero_ones", 64'h0, 1'b1, 1'b1);

    apply(1'b1, 1'b1, 2'd0, 64'hFF00, 64'h0FF0);
    expect3("stream0", 64'h0F00, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 2'd1, 64'hFF00, 64'h0FF0);
    expect3("stream1", 64'hFFF0, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 2'd2, 64'hFF00, 64'h0FF0);
    expect3("stream2", 64'hF0F0, 1'b0, 1'b1);

    apply(1'b1, 1'b0, 2'd1, '1, '1);
    expect3("hold_nz", 64'hF0F0, 1'b0, 1'b0);

    apply(1'b1, 1'b1, 2'd2, 64'h1, 64'h1);
    expect3("hold_cap", 64'h0, 1'b1, 1'b1);
    apply(1'b1, 1'b0, 2'd1, '1, 64'h0);
    expect3("hold_z", 64'h0, 1'b1, 1'b0);

    apply(1'b1, 1'b1, 2'd1, 64'hA5A5_0000_0000_00FF, 64'h1);
    expect3("wide_or", 64'hA5A5_0000_0000_00FF, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 2'd1, 64'h5, 64'h0);
    expect3("mid_reset", 64'h0, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 2'd1, 64'h5, 64'h0);
    expect3("post_reset", 64'h5, 1'b0, 1'b1);

    @(negedge clk);
    in_valid = 1'b0; a = 'x; b = 'x; ctrl = 'x;
    @(posedge clk); #1;
    expect3("x_iso", 64'h5, 1'b0, 1'b0);
    chk("x_known", {63'd0, $isunknown({out, zero, out_valid})}, 64'd0);

    apply(1'b1, 1'b1, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001);
    expect3("msb_xor", 64'h7FFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ab_gates_unit.md
AB_GATES_UNIT -- requirements
Module: ab_gates

Interface
REQ-001 Parameter WIDTH, default 64: operand and result width in bits, legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 a  input  WIDTH  operand A.
REQ-005 b  input  WIDTH  operand B.
REQ-006 ctrl  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 constant zero.
REQ-007 in_valid  input  1  high = a/b/ctrl are to be captured this cycle.
REQ-008 out  output  WIDTH  registered bitwise result.
REQ-009 out_valid  output  1  high for exactly the cycle(s) after a captured operation.
REQ-010 zero  output  1  registered flag: out is all zeros.

Function
REQ-011 Per bit i, the result SHALL be selected by a 4:1 mux with inputs {0: a[i]&b[i], 1: a[i]|b[i], 2: a[i]^b[i], 3: 1'b0} and select ctrl.
REQ-012 ctrl = 11 SHALL yield all-zero out, never X, for any a/b.
REQ-013 Latency SHALL be exactly 1 cycle: when in_valid = 1 at edge N, out/zero/out_valid reflect those inputs after edge N.
REQ-014 When in_valid = 0 at an edge, out and zero SHALL hold their previous values and out_valid SHALL go 0.
REQ-015 Back-to-back in_valid = 1 SHALL produce one result per cycle with no bubbles.
REQ-016 zero SHALL equal (result == 0) for the captured result and update only with out.
REQ-017 X/Z on a, b or ctrl while in_valid = 0 SHALL NOT propagate to any output.
REQ-018 No handshake backpressure; every captured operation is delivered the following cycle.

Reset
REQ-019 While reset = 0 at a rising edge: out = 0, zero = 1, out_valid = 0, regardless of in_valid.
REQ-020 Reset asserted mid-stream SHALL discard the operation captured that edge; the first post-reset result appears one cycle after the first in_valid = 1 with reset = 1.
REQ-021 No asynchronous path from reset to outputs.

Structure
REQ-022 A shared package SHALL hold the ctrl encoding as a 2-bit enum (OP_AND = 0, OP_OR = 1, OP_XOR = 2, OP_ZERO = 3) and the WIDTH default constant.
REQ-023 The combinational bit slice SHALL be one sub-module, ab_gates_bit (a, b, ctrl -> out), built from the 2-input AND, OR and XOR gate primitives and a 4:1 mux primitive (mux_4to1), instantiated WIDTH times via generate.
REQ-024 Only the top module holds registers; ab_gates_bit is purely combinational.

Verification
REQ-025 Reset: hold reset = 0 for 2 edges with in_valid = 1, a = b = all ones -> out = 0, zero = 1, out_valid = 0.
REQ-026 Truth table: for each ctrl 00..11, apply (a,b) bits = 0/0, 0/1, 1/0, 1/1 (WIDTH = 4, a = 4'b0011, b = 4'b0101):
- ctrl 00 -> 0001
- ctrl 01 -> 0111
- ctrl 10 -> 0110
- ctrl 11 -> 0000, zero = 1
REQ-027 Latency/streaming: in_valid = 1 on 3 consecutive cycles with ctrl 00, 01, 10 on a = 64'hFF00, b = 64'h0FF0 -> out = 0F00, FFF0, F0F0 on the 3 following cycles, out_valid = 1 each.
REQ-028 Hold: capture XOR of 64'h1 and 64'h1 (out = 0, zero = 1), then in_valid = 0 with a = all ones -> out stays 0, zero stays 1, out_valid = 0.
REQ-029 Reset mid-stream: in_valid = 1, ctrl = 01, a = 64'h5 with reset = 0 that edge -> out = 0, out_valid = 0; the next capture with reset = 1 -> out = 64'h5.
REQ-030 X isolation: a = X, in_valid = 0 -> outputs unchanged, no X on out, zero or out_valid.
